// File: rtl/sbox_arbiter_pkg.sv
// Shared definitions for the S-box arbiter: requester tags, base pipeline
// latency and the AES forward S-box lookup.
package sbox_arbiter_pkg;

    // Which requester a pipelined word belongs to
    typedef enum logic {
        TAG_KEY = 1'b0,
        TAG_RND = 1'b1
    } req_tag_e;

    // Cycles contributed by the registered S-box itself
    localparam int SBOX_LAT_BASE = 1;

    // AES forward S-box, entry 0 in the most significant byte
    localparam logic [2047:0] SBOX_ROM = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Byte b lives at bits [8*(255-b)+7 -: 8]; {~b, 3'b111} is that MSB index
    function automatic logic [7:0] sbox_byte(input logic [7:0] b);
        return SBOX_ROM[{~b, 3'b111} -: 8];
    endfunction

endpackage

// File: rtl/sbox_word.sv
// Registered 32-bit S-box: four independent byte lanes, each a ROM lookup
// with a registered output that clears to zero on reset.
module sbox_word
    import sbox_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in,
    output logic [31:0] out
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            logic [7:0] byte_reg;

            // Substitute this byte lane and hold the result for one cycle
            always_ff @(posedge clk) begin
                if (reset) begin
                    byte_reg <= 8'h00;
                end else begin
                    byte_reg <= sbox_byte(in[gi*8 +: 8]);
                end
            end

            assign out[gi*8 +: 8] = byte_reg;
        end
    endgenerate

endmodule

// File: rtl/sbox_arbiter.sv
// Two-requester arbiter in front of one shared registered S-box.
// Key-schedule and round-datapath requesters compete for a single lookup per
// cycle; each accepted word travels with a valid bit and a requester tag and
// comes back on its own response port PIPE_OUT+1 cycles later.
// Build option: define SBOX_ARB_FIXED_PRIO_EN to give ties to the key
// requester permanently instead of alternating.
module sbox_arbiter
    import sbox_arbiter_pkg::*;
#(
    parameter int PIPE_OUT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_req_valid,
    input  logic [31:0] key_req_word,
    output logic        key_req_ready,
    input  logic        rnd_req_valid,
    input  logic [31:0] rnd_req_word,
    output logic        rnd_req_ready,
    output logic        key_rsp_valid,
    output logic        rnd_rsp_valid,
    output logic [31:0] key_rsp_word,
    output logic [31:0] rnd_rsp_word,
    output logic        busy
);

    localparam int LATENCY = SBOX_LAT_BASE + PIPE_OUT;

    logic        grant_key;
    logic        grant_rnd;
    logic        accept;
    req_tag_e    acc_tag;
    logic [31:0] acc_word;

    // Stage A: the S-box register plus its sideband
    logic        valid_a_reg;
    req_tag_e    tag_a_reg;
    logic [31:0] sbox_out;

    // Last stage before the per-port response registers
    logic        fin_valid;
    req_tag_e    fin_tag;
    logic [31:0] fin_word;
    logic        extra_busy;

    logic        key_rsp_valid_reg;
    logic        rnd_rsp_valid_reg;
    logic [31:0] key_rsp_word_reg;
    logic [31:0] rnd_rsp_word_reg;

`ifndef SBOX_ARB_FIXED_PRIO_EN
    req_tag_e    last_grant_reg;
    req_tag_e    last_grant_next;

    // Remember who won the last accepted transfer; reset favours key next
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_reg <= TAG_RND;
        end else begin
            last_grant_reg <= last_grant_next;
        end
    end

    // Only an actual acceptance moves the round-robin pointer
    always_comb begin
        last_grant_next = last_grant_reg;
        if (accept) begin
            last_grant_next = acc_tag;
        end
    end
`endif

    // Pick at most one requester; nothing is granted while in reset
    always_comb begin
        grant_key = 1'b0;
        grant_rnd = 1'b0;
        if (!reset) begin
`ifdef SBOX_ARB_FIXED_PRIO_EN
            grant_key = key_req_valid;
`else
            grant_key = key_req_valid && (!rnd_req_valid || last_grant_reg == TAG_RND);
`endif
            grant_rnd = rnd_req_valid && !grant_key;
        end
    end

    assign key_req_ready = grant_key;
    assign rnd_req_ready = grant_rnd;
    assign accept        = grant_key || grant_rnd;
    assign acc_tag       = grant_rnd ? TAG_RND : TAG_KEY;
    assign acc_word      = grant_rnd ? rnd_req_word : key_req_word;

    // The S-box samples the muxed word every cycle; valid/tag say if it counts
    sbox_word u_sbox_word (
        .clk   (clk),
        .reset (reset),
        .in    (acc_word),
        .out   (sbox_out)
    );

    // Sideband travelling alongside the S-box register
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_a_reg <= 1'b0;
            tag_a_reg   <= TAG_KEY;
        end else begin
            valid_a_reg <= accept;
            tag_a_reg   <= acc_tag;
        end
    end

    generate
        if (LATENCY > SBOX_LAT_BASE) begin : g_out_pipe
            logic        valid_b_reg;
            req_tag_e    tag_b_reg;
            logic [31:0] word_b_reg;

            // Extra retiming stage between the S-box and the response ports
            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_b_reg <= 1'b0;
                    tag_b_reg   <= TAG_KEY;
                    word_b_reg  <= 32'h0;
                end else begin
                    valid_b_reg <= valid_a_reg;
                    tag_b_reg   <= tag_a_reg;
                    word_b_reg  <= sbox_out;
                end
            end

            assign fin_valid  = valid_b_reg;
            assign fin_tag    = tag_b_reg;
            assign fin_word   = word_b_reg;
            assign extra_busy = valid_b_reg;
        end else begin : g_no_out_pipe
            assign fin_valid  = valid_a_reg;
            assign fin_tag    = tag_a_reg;
            assign fin_word   = sbox_out;
            assign extra_busy = 1'b0;
        end
    endgenerate

    // Steer the finished word to its owner; words hold between pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            key_rsp_valid_reg <= 1'b0;
            rnd_rsp_valid_reg <= 1'b0;
            key_rsp_word_reg  <= 32'h0;
            rnd_rsp_word_reg  <= 32'h0;
        end else begin
            key_rsp_valid_reg <= fin_valid && (fin_tag == TAG_KEY);
            rnd_rsp_valid_reg <= fin_valid && (fin_tag == TAG_RND);
            if (fin_valid && (fin_tag == TAG_KEY)) begin
                key_rsp_word_reg <= fin_word;
            end
            if (fin_valid && (fin_tag == TAG_RND)) begin
                rnd_rsp_word_reg <= fin_word;
            end
        end
    end

    assign key_rsp_valid = key_rsp_valid_reg;
    assign rnd_rsp_valid = rnd_rsp_valid_reg;
    assign key_rsp_word  = key_rsp_word_reg;
    assign rnd_rsp_word  = rnd_rsp_word_reg;
    assign busy          = valid_a_reg || extra_busy;

endmodule

// File: tb/tb_sbox_arbiter.sv
// Testbench for sbox_arbiter: two instances (PIPE_OUT=0 and PIPE_OUT=1) share
// one set of inputs; a queue-based reference model predicts grants, response
// timing and values from the arbitration rules and an independent S-box table.
module tb_sbox_arbiter;

    localparam logic [7:0] SBOX_TBL [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    typedef struct {
        int          due;
        logic        tag;
        logic [31:0] word;
    } rsp_t;

    logic              clk;
    logic              reset;
    logic              key_req_valid;
    logic [31:0]       key_req_word;
    logic              rnd_req_valid;
    logic [31:0]       rnd_req_word;
    logic [1:0]        key_ready;
    logic [1:0]        rnd_ready;
    logic [1:0]        key_rsp_valid;
    logic [1:0]        rnd_rsp_valid;
    logic [1:0][31:0]  key_rsp_word;
    logic [1:0][31:0]  rnd_rsp_word;
    logic [1:0]        busy;

    int                tests_run;
    int                tests_failed;
    int                cyc;
    logic              verbose;
    logic              mdl_last_rnd;
    logic              obs_key_ready;
    logic              obs_rnd_ready;
    logic [1:0][31:0]  hold_key;
    logic [1:0][31:0]  hold_rnd;
    rsp_t              exp_q [2][$];

    sbox_arbiter #(.PIPE_OUT(0)) u_dut0 (
        .clk           (clk),
        .reset         (reset),
        .key_req_valid (key_req_valid),
        .key_req_word  (key_req_word),
        .key_req_ready (key_ready[0]),
        .rnd_req_valid (rnd_req_valid),
        .rnd_req_word  (rnd_req_word),
        .rnd_req_ready (rnd_ready[0]),
        .key_rsp_valid (key_rsp_valid[0]),
        .rnd_rsp_valid (rnd_rsp_valid[0]),
        .key_rsp_word  (key_rsp_word[0]),
        .rnd_rsp_word  (rnd_rsp_word[0]),
        .busy          (busy[0])
    );

    sbox_arbiter #(.PIPE_OUT(1)) u_dut1 (
        .clk           (clk),
        .reset         (reset),
        .key_req_valid (key_req_valid),
        .key_req_word  (key_req_word),
        .key_req_ready (key_ready[1]),
        .rnd_req_valid (rnd_req_valid),
        .rnd_req_word  (rnd_req_word),
        .rnd_req_ready (rnd_ready[1]),
        .key_rsp_valid (key_rsp_valid[1]),
        .rnd_rsp_valid (rnd_rsp_valid[1]),
        .key_rsp_word  (key_rsp_word[1]),
        .rnd_rsp_word  (rnd_rsp_word[1]),
        .busy          (busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX_TBL[w[31:24]], SBOX_TBL[w[23:16]], SBOX_TBL[w[15:8]], SBOX_TBL[w[7:0]]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, got, exp);
        end
    endtask

    // One clock of stimulus: drive at negedge, check readies, model the edge,
    // then check every response output of both instances at the next negedge.
    task automatic step(input logic rst, input logic kv, input logic [31:0] kw,
                        input logic rv, input logic [31:0] rw);
        logic exp_k;
        logic exp_r;
        logic ek;
        logic er;
        rsp_t e;
        reset         = rst;
        key_req_valid = kv;
        key_req_word  = kw;
        rnd_req_valid = rv;
        rnd_req_word  = rw;
        #1;
        if (rst) begin
            exp_k = 1'b0;
            exp_r = 1'b0;
        end else if (kv && rv) begin
`ifdef SBOX_ARB_FIXED_PRIO_EN
            exp_k = 1'b1;
`else
            exp_k = mdl_last_rnd;
`endif
            exp_r = !exp_k;
        end else begin
            exp_k = kv;
            exp_r = rv;
        end
        obs_key_ready = key_ready[1];
        obs_rnd_ready = rnd_ready[1];
        for (int i = 0; i < 2; i++) begin
            check($sformatf("key_ready[%0d]", i), {31'b0, key_ready[i]}, {31'b0, exp_k});
            check($sformatf("rnd_ready[%0d]", i), {31'b0, rnd_ready[i]}, {31'b0, exp_r});
            check($sformatf("dual_ready[%0d]", i), {31'b0, key_ready[i] & rnd_ready[i]}, 32'h0);
        end
        @(posedge clk);
        cyc++;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                exp_q[i].delete();
                hold_key[i] = 32'h0;
                hold_rnd[i] = 32'h0;
            end
            mdl_last_rnd = 1'b1;
        end else if (exp_k || exp_r) begin
            for (int i = 0; i < 2; i++) begin
                e.due  = cyc + 1 + i;
                e.tag  = exp_r;
                e.word = sub_word(exp_k ? kw : rw);
                exp_q[i].push_back(e);
            end
            mdl_last_rnd = exp_r;
            if (verbose) begin
                $display("[TB] cycle %0d accept %s word %h -> expect %h", cyc,
                         exp_r ? "rnd" : "key", exp_k ? kw : rw, sub_word(exp_k ? kw : rw));
            end
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            ek = 1'b0;
            er = 1'b0;
            if (exp_q[i].size() > 0 && exp_q[i][0].due == cyc) begin
                e = exp_q[i].pop_front();
                if (e.tag) begin
                    er = 1'b1;
                    hold_rnd[i] = e.word;
                end else begin
                    ek = 1'b1;
                    hold_key[i] = e.word;
                end
            end
            check($sformatf("key_rsp_valid[%0d]", i), {31'b0, key_rsp_valid[i]}, {31'b0, ek});
            check($sformatf("rnd_rsp_valid[%0d]", i), {31'b0, rnd_rsp_valid[i]}, {31'b0, er});
            check($sformatf("key_rsp_word[%0d]", i), key_rsp_word[i], hold_key[i]);
            check($sformatf("rnd_rsp_word[%0d]", i), rnd_rsp_word[i], hold_rnd[i]);
            check($sformatf("busy[%0d]", i), {31'b0, busy[i]}, {31'b0, exp_q[i].size() != 0});
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        logic [3:0] rr_seq;
        tests_run     = 0;
        tests_failed  = 0;
        cyc           = 0;
        verbose       = 1'b1;
        mdl_last_rnd  = 1'b1;
        hold_key      = '0;
        hold_rnd      = '0;
        reset         = 1'b1;
        key_req_valid = 1'b0;
        key_req_word  = 32'h0;
        rnd_req_valid = 1'b0;
        rnd_req_word  = 32'h0;
`ifdef SBOX_ARB_FIXED_PRIO_EN
        rr_seq = 4'b0000;
`else
        rr_seq = 4'b1010;
`endif
        @(negedge clk);

        // Reset with both requesters asking: no readies, everything cleared
        step(1'b1, 1'b1, $urandom, 1'b1, $urandom);
        step(1'b1, 1'b1, $urandom, 1'b1, $urandom);
        for (int i = 0; i < 2; i++) begin
            check("rst_busy", {31'b0, busy[i]}, 32'h0);
            check("rst_key_word", key_rsp_word[i], 32'h0);
            check("rst_rnd_word", rnd_rsp_word[i], 32'h0);
        end

        // Single key request
        step(1'b0, 1'b1, 32'h00010253, 1'b0, 32'h0);
        idle(3);
        check("key_single_word0", key_rsp_word[0], 32'h637C77ED);
        check("key_single_word1", key_rsp_word[1], 32'h637C77ED);

        // Both valid for four cycles straight after reset
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, $urandom, 1'b1, $urandom);
            check("tie_grant_rnd", {31'b0, obs_rnd_ready}, {31'b0, rr_seq[k]});
            check("tie_grant_key", {31'b0, obs_key_ready}, {31'b0, !rr_seq[k]});
        end
        idle(3);

        // Reset kills an in-flight round word; the next request is normal
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFFFFFF);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        idle(3);
        check("flush_rnd_word", rnd_rsp_word[1], 32'h0);
        step(1'b0, 1'b1, 32'h01020304, 1'b0, 32'h0);
        idle(3);
        check("post_flush_key", key_rsp_word[1], 32'h7C777BF2);

        // Round word through both latencies
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h53535353);
        idle(2);
        check("rnd_5353_p0", rnd_rsp_word[0], 32'hEDEDEDED);
        check("rnd_5353_p1", rnd_rsp_word[1], 32'hEDEDEDED);

        // Random traffic with occasional reset
        verbose = 1'b0;
        for (int k = 0; k < 10000; k++) begin
            step($urandom_range(199) == 0,
                 $urandom_range(9) < 6, $urandom,
                 $urandom_range(9) < 6, $urandom);
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
